// File: rtl/tmr_multi_ctrl.sv
// N-channel timer controller: per-channel compare-match counters, TMO waveform, clear-source
// selection with synchronised TMRI, sticky flags, interrupts, ADC trigger and pair cascading.
module tmr_multi_ctrl #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_CH-1:0]       i_cnt_en,
  input  logic [NUM_CH*CNT_W-1:0] i_tcora,
  input  logic [NUM_CH*CNT_W-1:0] i_tcorb,
  input  logic [NUM_CH*3-1:0]     i_cclr,
  input  logic [NUM_CH*2-1:0]     i_os_a,
  input  logic [NUM_CH*2-1:0]     i_os_b,
  input  logic [NUM_CH/2-1:0]     i_cascade,
  input  logic [NUM_CH-1:0]       i_tmri,
  input  logic [NUM_CH-1:0]       i_ie_cma,
  input  logic [NUM_CH-1:0]       i_ie_cmb,
  input  logic [NUM_CH-1:0]       i_ie_ovf,
  input  logic [NUM_CH-1:0]       i_flag_clr_cma,
  input  logic [NUM_CH-1:0]       i_flag_clr_cmb,
  input  logic [NUM_CH-1:0]       i_flag_clr_ovf,
  input  logic                    i_adte,
  output logic [NUM_CH*CNT_W-1:0] o_tcnt,
  output logic [NUM_CH-1:0]       o_tmo,
  output logic [NUM_CH-1:0]       o_cmf_a,
  output logic [NUM_CH-1:0]       o_cmf_b,
  output logic [NUM_CH-1:0]       o_ovf,
  output logic [NUM_CH-1:0]       o_cmi_a,
  output logic [NUM_CH-1:0]       o_cmi_b,
  output logic [NUM_CH-1:0]       o_ovi,
  output logic                    o_adc_trig
);

  localparam int unsigned NUM_PAIR = NUM_CH / 2;

  logic [CNT_W-1:0]       cnt_q [NUM_CH];
  logic [CNT_W-1:0]       cnt_d [NUM_CH];
  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [NUM_CH-1:0]      dly_q;
  logic [NUM_CH-1:0]      tmo_q, tmo_d, cmf_a_q, cmf_a_d, cmf_b_q, cmf_b_d, ovf_q, ovf_d;
  logic                   adc_q, adc_d;

  logic [NUM_CH-1:0]      tick, ev_a, ev_b, ev_ovf, clr, lvl, lvl_dly;
  logic [2:0]             sel [NUM_CH];

  function automatic logic clr_hit(input logic [2:0] s, input logic ea, input logic eb,
                                   input logic l, input logic ld);
    case (s)
      3'd1:    clr_hit = ea;
      3'd2:    clr_hit = eb;
      3'd3:    clr_hit = l & ~ld;
      3'd4:    clr_hit = ~l & ld;
      3'd5:    clr_hit = l ^ ld;
      3'd6:    clr_hit = l;
      3'd7:    clr_hit = ~l;
      default: clr_hit = 1'b0;
    endcase
  endfunction

  function automatic logic tmo_apply(input logic cur, input logic [1:0] os);
    case (os)
      2'd1:    tmo_apply = 1'b0;
      2'd2:    tmo_apply = 1'b1;
      2'd3:    tmo_apply = ~cur;
      default: tmo_apply = cur;
    endcase
  endfunction

  // Tick, match and clear-source routing; a cascaded pair uses the high channel's clear and TMRI.
  always_comb begin
    tick    = '0;
    ev_a    = '0;
    ev_b    = '0;
    lvl     = '0;
    lvl_dly = '0;
    for (int c = 0; c < NUM_CH; c++) sel[c] = 3'd0;
    for (int k = 0; k < NUM_PAIR; k++) begin
      if (i_cascade[k]) begin
        tick[2*k]   = i_cnt_en[2*k];
        tick[2*k+1] = i_cnt_en[2*k] & (cnt_q[2*k] == '1);
        ev_a[2*k]   = i_cnt_en[2*k] &
                      ({cnt_q[2*k+1], cnt_q[2*k]} == i_tcora[2*k*CNT_W +: 2*CNT_W]);
        ev_b[2*k]   = i_cnt_en[2*k] &
                      ({cnt_q[2*k+1], cnt_q[2*k]} == i_tcorb[2*k*CNT_W +: 2*CNT_W]);
        ev_a[2*k+1] = ev_a[2*k];
        ev_b[2*k+1] = ev_b[2*k];
        for (int j = 0; j < 2; j++) begin
          sel[2*k+j]     = i_cclr[(2*k+1)*3 +: 3];
          lvl[2*k+j]     = sync_q[2*k+1][SYNC_STAGES-1];
          lvl_dly[2*k+j] = dly_q[2*k+1];
        end
      end else begin
        for (int j = 0; j < 2; j++) begin
          tick[2*k+j]    = i_cnt_en[2*k+j];
          ev_a[2*k+j]    = i_cnt_en[2*k+j] & (cnt_q[2*k+j] == i_tcora[(2*k+j)*CNT_W +: CNT_W]);
          ev_b[2*k+j]    = i_cnt_en[2*k+j] & (cnt_q[2*k+j] == i_tcorb[(2*k+j)*CNT_W +: CNT_W]);
          sel[2*k+j]     = i_cclr[(2*k+j)*3 +: 3];
          lvl[2*k+j]     = sync_q[2*k+j][SYNC_STAGES-1];
          lvl_dly[2*k+j] = dly_q[2*k+j];
        end
      end
    end
  end

  // Counter next state and overflow; any clear beats the increment and suppresses overflow.
  always_comb begin
    clr    = '0;
    ev_ovf = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      clr[c]    = clr_hit(sel[c], ev_a[c], ev_b[c], lvl[c], lvl_dly[c]);
      ev_ovf[c] = tick[c] & (cnt_q[c] == '1) & ~clr[c];
      if (clr[c])       cnt_d[c] = '0;
      else if (tick[c]) cnt_d[c] = cnt_q[c] + CNT_W'(1);
      else              cnt_d[c] = cnt_q[c];
    end
  end

  // TMO action select (B wins on a double match unless B holds), sticky flags, ADC pulse.
  always_comb begin
    logic [1:0] act;
    act     = 2'd0;
    tmo_d   = tmo_q;
    cmf_a_d = cmf_a_q;
    cmf_b_d = cmf_b_q;
    ovf_d   = ovf_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ev_a[c] && ev_b[c]) act = (i_os_b[c*2 +: 2] != 2'd0) ? i_os_b[c*2 +: 2] : i_os_a[c*2 +: 2];
      else if (ev_a[c])       act = i_os_a[c*2 +: 2];
      else if (ev_b[c])       act = i_os_b[c*2 +: 2];
      else                    act = 2'd0;
      tmo_d[c]   = tmo_apply(tmo_q[c], act);
      cmf_a_d[c] = ev_a[c] | (cmf_a_q[c] & ~i_flag_clr_cma[c]);
      cmf_b_d[c] = ev_b[c] | (cmf_b_q[c] & ~i_flag_clr_cmb[c]);
      ovf_d[c]   = ev_ovf[c] | (ovf_q[c] & ~i_flag_clr_ovf[c]);
    end
    adc_d = ev_a[0] & i_adte;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= '0;
        sync_q[c] <= '0;
      end
      dly_q   <= '0;
      tmo_q   <= '0;
      cmf_a_q <= '0;
      cmf_b_q <= '0;
      ovf_q   <= '0;
      adc_q   <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= cnt_d[c];
        sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], i_tmri[c]};
        dly_q[c]  <= sync_q[c][SYNC_STAGES-1];
      end
      tmo_q   <= tmo_d;
      cmf_a_q <= cmf_a_d;
      cmf_b_q <= cmf_b_d;
      ovf_q   <= ovf_d;
      adc_q   <= adc_d;
    end
  end

  always_comb begin
    o_tcnt = '0;
    for (int c = 0; c < NUM_CH; c++) o_tcnt[c*CNT_W +: CNT_W] = cnt_q[c];
  end

  assign o_tmo      = tmo_q;
  assign o_cmf_a    = cmf_a_q;
  assign o_cmf_b    = cmf_b_q;
  assign o_ovf      = ovf_q;
  assign o_cmi_a    = cmf_a_q & i_ie_cma;
  assign o_cmi_b    = cmf_b_q & i_ie_cmb;
  assign o_ovi      = ovf_q & i_ie_ovf;
  assign o_adc_trig = adc_q;

endmodule

// File: tb/tb_tmr_multi_ctrl.sv
// Self-checking bench for tmr_multi_ctrl: directed scenarios plus randomized traffic,
// all compared each cycle against an integer-arithmetic reference model.
module tb_tmr_multi_ctrl;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int SYNC   = 2;
  localparam int NP     = NUM_CH / 2;
  localparam int MAXV   = 2 ** CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NUM_CH-1:0]       cnt_en, tmri, ie_cma, ie_cmb, ie_ovf, fc_cma, fc_cmb, fc_ovf;
  logic [NUM_CH*CNT_W-1:0] tcora, tcorb, o_tcnt;
  logic [NUM_CH*3-1:0]     cclr;
  logic [NUM_CH*2-1:0]     os_a, os_b;
  logic [NP-1:0]           cascade;
  logic                    adte, o_adc_trig;
  logic [NUM_CH-1:0]       o_tmo, o_cmf_a, o_cmf_b, o_ovf, o_cmi_a, o_cmi_b, o_ovi;

  always #5 clk = ~clk;

  tmr_multi_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .i_clk(clk), .i_rst(rst), .i_cnt_en(cnt_en), .i_tcora(tcora), .i_tcorb(tcorb),
    .i_cclr(cclr), .i_os_a(os_a), .i_os_b(os_b), .i_cascade(cascade), .i_tmri(tmri),
    .i_ie_cma(ie_cma), .i_ie_cmb(ie_cmb), .i_ie_ovf(ie_ovf),
    .i_flag_clr_cma(fc_cma), .i_flag_clr_cmb(fc_cmb), .i_flag_clr_ovf(fc_ovf),
    .i_adte(adte), .o_tcnt(o_tcnt), .o_tmo(o_tmo), .o_cmf_a(o_cmf_a), .o_cmf_b(o_cmf_b),
    .o_ovf(o_ovf), .o_cmi_a(o_cmi_a), .o_cmi_b(o_cmi_b), .o_ovi(o_ovi), .o_adc_trig(o_adc_trig)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: counters as integers, TMRI as a delay line of sampled pin values.
  int                mcnt [NUM_CH];
  logic [NUM_CH-1:0] mtmo, mcmfa, mcmfb, movf;
  logic              madc;
  logic [NUM_CH-1:0] hist [SYNC+1];
  int                ncnt [NUM_CH];
  logic [NUM_CH-1:0] nea, neb, nov, ntmo, ncmfa, ncmfb, novf;
  logic              nadc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fld(input logic [NUM_CH*CNT_W-1:0] v, input int c);
    return 32'(v[c*CNT_W +: CNT_W]);
  endfunction

  function automatic bit clr_rule(input int s, input bit ea, input bit eb, input bit l, input bit ld);
    case (s)
      1: return ea;
      2: return eb;
      3: return l && !ld;
      4: return !l && ld;
      5: return l != ld;
      6: return l;
      7: return !l;
      default: return 1'b0;
    endcase
  endfunction

  // One counter of modulus m: match, clear and next value.
  task automatic seg(input int m, input int v, input int a, input int b, input int s,
                     input bit tk, input bit l, input bit ld,
                     output int nv, output bit ea, output bit eb, output bit cl);
    ea = tk && (v == a);
    eb = tk && (v == b);
    cl = clr_rule(s, ea, eb, l, ld);
    nv = cl ? 0 : (tk ? (v + 1) % m : v);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mcnt[c] = 0;
    mtmo = '0; mcmfa = '0; mcmfb = '0; movf = '0; madc = 1'b0;
    for (int i = 0; i <= SYNC; i++) hist[i] = '0;
  endtask

  task automatic model_compute();
    int nv, v, a, b, lo, hi, act, oa, ob;
    bit ea, eb, cl;
    for (int k = 0; k < NP; k++) begin
      lo = 2 * k;
      hi = 2 * k + 1;
      if (cascade[k]) begin
        v = mcnt[hi] * MAXV + mcnt[lo];
        a = fld(tcora, hi) * MAXV + fld(tcora, lo);
        b = fld(tcorb, hi) * MAXV + fld(tcorb, lo);
        seg(MAXV * MAXV, v, a, b, int'(cclr[hi*3 +: 3]), cnt_en[lo],
            hist[SYNC-1][hi], hist[SYNC][hi], nv, ea, eb, cl);
        ncnt[lo] = nv % MAXV;
        ncnt[hi] = nv / MAXV;
        nea[lo] = ea; nea[hi] = ea;
        neb[lo] = eb; neb[hi] = eb;
        nov[lo] = cnt_en[lo] && (mcnt[lo] == MAXV - 1) && !cl;
        nov[hi] = cnt_en[lo] && (v == MAXV * MAXV - 1) && !cl;
      end else begin
        for (int j = 0; j < 2; j++) begin
          v = mcnt[lo + j];
          seg(MAXV, v, fld(tcora, lo + j), fld(tcorb, lo + j), int'(cclr[(lo+j)*3 +: 3]),
              cnt_en[lo + j], hist[SYNC-1][lo + j], hist[SYNC][lo + j], nv, ea, eb, cl);
          ncnt[lo + j] = nv;
          nea[lo + j] = ea;
          neb[lo + j] = eb;
          nov[lo + j] = cnt_en[lo + j] && (v == MAXV - 1) && !cl;
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      oa = int'(os_a[c*2 +: 2]);
      ob = int'(os_b[c*2 +: 2]);
      if (nea[c] && neb[c]) act = (ob != 0) ? ob : oa;
      else if (nea[c])      act = oa;
      else if (neb[c])      act = ob;
      else                  act = 0;
      ntmo[c]  = (act == 1) ? 1'b0 : (act == 2) ? 1'b1 : (act == 3) ? !mtmo[c] : mtmo[c];
      ncmfa[c] = nea[c] || (mcmfa[c] && !fc_cma[c]);
      ncmfb[c] = neb[c] || (mcmfb[c] && !fc_cmb[c]);
      novf[c]  = nov[c] || (movf[c] && !fc_ovf[c]);
    end
    nadc = nea[0] && adte;
  endtask

  task automatic check_all();
    logic [NUM_CH*CNT_W-1:0] et;
    for (int c = 0; c < NUM_CH; c++) et[c*CNT_W +: CNT_W] = CNT_W'(mcnt[c]);
    chk("tcnt",  64'(o_tcnt),  64'(et));
    chk("tmo",   64'(o_tmo),   64'(mtmo));
    chk("cmf_a", 64'(o_cmf_a), 64'(mcmfa));
    chk("cmf_b", 64'(o_cmf_b), 64'(mcmfb));
    chk("ovf",   64'(o_ovf),   64'(movf));
    chk("cmi_a", 64'(o_cmi_a), 64'(mcmfa & ie_cma));
    chk("cmi_b", 64'(o_cmi_b), 64'(mcmfb & ie_cmb));
    chk("ovi",   64'(o_ovi),   64'(movf & ie_ovf));
    chk("adc",   64'(o_adc_trig), 64'(madc));
  endtask

  task automatic step();
    model_compute();
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) mcnt[c] = ncnt[c];
    mtmo = ntmo; mcmfa = ncmfa; mcmfb = ncmfb; movf = novf; madc = nadc;
    for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = tmri;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic defaults();
    cnt_en = '0; tmri = '0; ie_cma = '0; ie_cmb = '0; ie_ovf = '0;
    fc_cma = '0; fc_cmb = '0; fc_ovf = '0; tcora = '0; tcorb = '0;
    cclr = '0; os_a = '0; os_b = '0; cascade = '0; adte = 1'b0;
  endtask

  // Asserted away from the clock edge so the asynchronous clear is observed mid-cycle.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic random_cfg();
    for (int c = 0; c < NUM_CH; c++) begin
      tcora[c*CNT_W +: CNT_W] = ($urandom_range(0, 7) == 0) ? CNT_W'(MAXV - 1) : CNT_W'($urandom_range(0, 20));
      tcorb[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 24));
      cclr[c*3 +: 3] = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(1, 2)) : 3'($urandom_range(0, 7));
    end
    os_a = (NUM_CH*2)'($urandom); os_b = (NUM_CH*2)'($urandom);
    ie_cma = NUM_CH'($urandom); ie_cmb = NUM_CH'($urandom); ie_ovf = NUM_CH'($urandom);
    cascade = NP'($urandom); adte = 1'($urandom);
  endtask

  initial begin
    defaults();
    model_reset();
    #2;
    do_reset();

    // Ch0 period TCORA+1 with toggling TMO.
    tcora[7:0] = 8'd5; cclr[2:0] = 3'd1; os_a[1:0] = 2'd3; cnt_en = 4'b0001;
    steps(6);
    chk("ch0_wrap_cnt", 64'(o_tcnt[7:0]), 64'd0);
    chk("ch0_first_cmfa", 64'(o_cmf_a[0]), 64'd1);
    chk("ch0_first_tmo", 64'(o_tmo[0]), 64'd1);
    steps(6);
    chk("ch0_second_tmo", 64'(o_tmo[0]), 64'd0);

    // Simultaneous A/B match priority on ch2.
    defaults(); do_reset();
    tcora[23:16] = 8'd3; tcorb[23:16] = 8'd3; cclr[8:6] = 3'd1;
    os_a[5:4] = 2'd2; os_b[5:4] = 2'd1; cnt_en = 4'b0100;
    steps(4);
    chk("both_match_osb", 64'(o_tmo[2]), 64'd0);
    os_b[5:4] = 2'd0;
    steps(4);
    chk("both_match_osb0", 64'(o_tmo[2]), 64'd1);

    // Ch1 overflow, then set-beats-clear.
    defaults(); do_reset();
    ie_ovf = 4'b0010; cnt_en = 4'b0010;
    steps(256);
    chk("ovf_set", 64'(o_ovf[1]), 64'd1);
    chk("ovi_set", 64'(o_ovi[1]), 64'd1);
    steps(255);
    fc_ovf = 4'b0010;
    step();
    chk("ovf_set_wins", 64'(o_ovf[1]), 64'd1);
    step();
    chk("ovf_cleared", 64'(o_ovf[1]), 64'd0);
    fc_ovf = '0;

    // Cascade pair 0 with compare clear at 0x0102.
    defaults(); do_reset();
    cascade = 2'b01; tcora[15:0] = 16'h0102; cclr[5:3] = 3'd1; cnt_en = 4'b0001;
    steps(256);
    chk("casc_cnt_100", 64'(o_tcnt[15:0]), 64'h0100);
    chk("casc_ovf_lo", 64'(o_ovf[1:0]), 64'b01);
    steps(3);
    chk("casc_clear", 64'(o_tcnt[15:0]), 64'h0000);
    chk("casc_cmfa_both", 64'(o_cmf_a[1:0]), 64'b11);

    // TMRI rising-edge clear latency, then level hold.
    defaults(); do_reset();
    cclr[2:0] = 3'd3; cnt_en = 4'b0001;
    steps(64);
    tmri[0] = 1'b1;
    steps(SYNC);
    chk("tmri_pre_clear", 64'(o_tcnt[7:0]), 64'h42);
    step();
    chk("tmri_edge_clear", 64'(o_tcnt[7:0]), 64'h00);
    cclr[2:0] = 3'd6;
    steps(5);
    chk("tmri_level_hold", 64'(o_tcnt[7:0]), 64'h00);

    // ADC trigger pulse, then mid-count reset.
    defaults(); do_reset();
    tcora[7:0] = 8'd2; cclr[2:0] = 3'd1; adte = 1'b1; cnt_en = 4'b1111;
    steps(3);
    chk("adc_pulse", 64'(o_adc_trig), 64'd1);
    step();
    chk("adc_single", 64'(o_adc_trig), 64'd0);
    steps(7);
    do_reset();

    // Randomized traffic.
    for (int r = 0; r < 16; r++) begin
      random_cfg();
      for (int n = 0; n < 160; n++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          cnt_en[c] = ($urandom_range(0, 3) != 0);
          fc_cma[c] = ($urandom_range(0, 15) == 0);
          fc_cmb[c] = ($urandom_range(0, 15) == 0);
          fc_ovf[c] = ($urandom_range(0, 15) == 0);
        end
        if ($urandom_range(0, 7) == 0) tmri = tmri ^ (NUM_CH'(1) << $urandom_range(0, NUM_CH - 1));
        if ($urandom_range(0, 63) == 0) cascade = NP'($urandom);
        step();
      end
      if (r % 5 == 4) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
